// File: rtl/mq2_pkg.sv
// mq2_pkg: shared definitions for the MQ-2 gas alarm controller.
//   - state_e            : controller FSM state encoding
//   - DEF_*              : default timing parameters (in clk cycles)
//   - cnt_width()        : counter width helper, never narrower than 1 bit
package mq2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_MONITOR = 3'd2,
        ST_ALARM   = 3'd3,
        ST_CLEARED = 3'd4
    } state_e;

    localparam int unsigned DEF_WARMUP_CYCLES   = 50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEF_BEEP_HALF       = 12_500_000;

    // A counter that runs 0..n-1 needs $clog2(n) bits; keep at least one bit
    // so a parameter of 1 still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mq2_debounce.sv
// mq2_debounce: synchronizes the active-low MQ-2 comparator output and
// debounces the resulting gas-present level.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (synchronizer flops go to 1 = no gas)
//   din  - raw asynchronous comparator output, active-low
//   dout - debounced gas-present level, active-high
module mq2_debounce
    import mq2_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             gas_raw_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // gas_raw is registered after the two synchronizer flops; together with
    // the FSM register this gives a fixed DEBOUNCE_CYCLES+3 input-to-alarm
    // latency.  The counter only runs while gas_raw disagrees with the
    // accepted level, and flips that level on the DEBOUNCE_CYCLES-th
    // consecutive disagreeing cycle, so it never exceeds DEBOUNCE_CYCLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            gas_raw_q <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= din;
            sync2_q   <= sync1_q;
            gas_raw_q <= ~sync2_q;
            if (gas_raw_q != stable_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q <= gas_raw_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/mq2_alarm_ctrl.sv
// mq2_alarm_ctrl: MQ-2 gas sensor alarm controller.
// Sequences sensor warm-up, monitors the debounced gas level, drives an
// alarm LED and a pulsing buzzer, and counts alarm entries.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   enable    - 1 = armed, 0 = forced idle
//   da_in     - MQ-2 comparator output, asynchronous, active-low
//   ack       - operator acknowledge (level)
//   t_led     - alarm indicator LED
//   buzzer    - audible alarm drive
//   ready     - warm-up complete, monitoring active
//   alarm     - debounced gas present while armed
//   alarm_cnt - saturating count of alarm entries
module mq2_alarm_ctrl
    import mq2_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES   = DEF_WARMUP_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned BEEP_HALF       = DEF_BEEP_HALF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       da_in,
    input  logic       ack,
    output logic       t_led,
    output logic       buzzer,
    output logic       ready,
    output logic       alarm,
    output logic [7:0] alarm_cnt
);

    localparam int unsigned WARM_W = cnt_width(WARMUP_CYCLES);
    localparam int unsigned BEEP_W = cnt_width(BEEP_HALF);

    state_e            state_q,    state_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              buzz_q,     buzz_d;
    logic              silence_q,  silence_d;
    logic [7:0]        alarm_cnt_q, alarm_cnt_d;
    logic              gas_stable;
    logic              deb_rst;
    logic              enter_alarm;

    // Dropping enable also flushes the debouncer so re-arming starts clean.
    assign deb_rst = rst | ~enable;

    mq2_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk (clk),
        .rst (deb_rst),
        .din (da_in),
        .dout(gas_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            warm_cnt_q  <= '0;
            beep_cnt_q  <= '0;
            buzz_q      <= 1'b0;
            silence_q   <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            beep_cnt_q  <= beep_cnt_d;
            buzz_q      <= buzz_d;
            silence_q   <= silence_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        beep_cnt_d  = beep_cnt_q;
        buzz_d      = buzz_q;
        silence_d   = silence_q;
        alarm_cnt_d = alarm_cnt_q;
        enter_alarm = 1'b0;
        t_led       = 1'b0;
        buzzer      = 1'b0;
        ready       = 1'b0;
        alarm       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_WARMUP;
                    warm_cnt_d = '0;
                end
            end
            ST_WARMUP: begin
                if (warm_cnt_q == WARM_W'(WARMUP_CYCLES - 1)) begin
                    state_d = ST_MONITOR;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            ST_MONITOR: begin
                ready = 1'b1;
                if (gas_stable) begin
                    enter_alarm = 1'b1;
                end
            end
            ST_ALARM: begin
                ready  = 1'b1;
                alarm  = 1'b1;
                t_led  = 1'b1;
                buzzer = buzz_q & ~silence_q;
                if (ack) begin
                    silence_d = 1'b1;
                end
                if (beep_cnt_q == BEEP_W'(BEEP_HALF - 1)) begin
                    beep_cnt_d = '0;
                    buzz_d     = ~buzz_q;
                end else begin
                    beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                end
                if (!gas_stable) begin
                    state_d    = ST_CLEARED;
                    silence_d  = 1'b0;
                    beep_cnt_d = '0;
                    buzz_d     = 1'b0;
                end
            end
            ST_CLEARED: begin
                ready = 1'b1;
                t_led = 1'b1;
                // Fresh gas outranks a simultaneous acknowledge.
                if (gas_stable) begin
                    enter_alarm = 1'b1;
                end else if (ack) begin
                    state_d = ST_MONITOR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every ALARM entry restarts the beep pattern with the buzzer on.
        if (enter_alarm) begin
            state_d    = ST_ALARM;
            buzz_d     = 1'b1;
            beep_cnt_d = '0;
            silence_d  = 1'b0;
            if (alarm_cnt_q != 8'hFF) begin
                alarm_cnt_d = alarm_cnt_q + 8'd1;
            end
        end

        if (!enable) begin
            state_d    = ST_IDLE;
            warm_cnt_d = '0;
            beep_cnt_d = '0;
            buzz_d     = 1'b0;
            silence_d  = 1'b0;
        end
    end

    assign alarm_cnt = alarm_cnt_q;

endmodule

// File: tb/tb_mq2_alarm_ctrl.sv
// tb_mq2_alarm_ctrl: directed self-checking bench for mq2_alarm_ctrl with
// WARMUP_CYCLES=100, DEBOUNCE_CYCLES=4, BEEP_HALF=8.
// Output pattern nibble is {t_led, buzzer, ready, alarm}.
module tb_mq2_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       da_in;
    logic       ack;
    logic       t_led;
    logic       buzzer;
    logic       ready;
    logic       alarm;
    logic [7:0] alarm_cnt;

    int checks = 0;
    int errors = 0;

    mq2_alarm_ctrl #(
        .WARMUP_CYCLES  (100),
        .DEBOUNCE_CYCLES(4),
        .BEEP_HALF      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .da_in    (da_in),
        .ack      (ack),
        .t_led    (t_led),
        .buzzer   (buzzer),
        .ready    (ready),
        .alarm    (alarm),
        .alarm_cnt(alarm_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] outs;
    assign outs = {4'd0, t_led, buzzer, ready, alarm};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        da_in  = 1'b1;
        ack    = 1'b0;
        tick(2);
        check("reset_outs", outs, 8'h00);
        check("reset_cnt", alarm_cnt, 8'd0);

        // Arm: IDLE->WARMUP on the first edge, 100 cycles of WARMUP.
        rst    = 1'b0;
        enable = 1'b1;
        tick(100);
        check("warmup_end", outs, 8'h00);
        tick(1);
        check("monitor", outs, 8'h02);

        // 3-cycle glitch must not alarm and must leave the debouncer idle.
        da_in = 1'b0;
        tick(3);
        da_in = 1'b1;
        tick(10);
        check("glitch_outs", outs, 8'h02);
        check("glitch_debcnt", 8'(dut.u_deb.cnt_q), 8'd0);

        // Held gas: alarm rises exactly 7 cycles after the first sampling edge.
        da_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("latency_pre", outs, 8'h02);
        end
        tick(1);
        check("alarm_entry", outs, 8'h0F);
        check("alarm_cnt1", alarm_cnt, 8'd1);
        tick(7);
        check("beep_hi_end", outs, 8'h0F);
        tick(1);
        check("beep_lo", outs, 8'h0B);
        tick(7);
        check("beep_lo_end", outs, 8'h0B);
        tick(1);
        check("beep_hi2", outs, 8'h0F);

        // Acknowledge silences the buzzer; LED stays on.
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("ack_silence", outs, 8'h0B);
        tick(10);
        check("still_silent", outs, 8'h0B);

        // Gas clears -> CLEARED, then acknowledge -> MONITOR.
        da_in = 1'b1;
        tick(7);
        check("clear_pre", outs, 8'h0B);
        tick(1);
        check("cleared", outs, 8'h0A);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("ack_monitor", outs, 8'h02);
        check("cnt_after_ack", alarm_cnt, 8'd1);

        // Repeated ALARM/CLEARED cycles drive the counter to saturation.
        for (int i = 0; i < 253; i++) begin
            da_in = 1'b0;
            tick(8);
            da_in = 1'b1;
            tick(8);
        end
        check("cnt_254", alarm_cnt, 8'd254);
        da_in = 1'b0;
        tick(8);
        check("cnt_255", alarm_cnt, 8'd255);
        da_in = 1'b1;
        tick(8);
        da_in = 1'b0;
        tick(8);
        check("cnt_sat", alarm_cnt, 8'd255);
        check("sat_alarm", outs, 8'h0F);

        // Disarm mid-alarm: IDLE on the next edge, count retained.
        enable = 1'b0;
        tick(1);
        check("disarm_outs", outs, 8'h00);
        check("disarm_cnt", alarm_cnt, 8'd255);

        // Re-arm with gas still present: WARMUP, MONITOR, then ALARM.
        enable = 1'b1;
        tick(101);
        check("rearm_monitor", outs, 8'h02);
        tick(1);
        check("rearm_alarm", outs, 8'h0F);
        check("rearm_cnt", alarm_cnt, 8'd255);

        // Reset mid-alarm beats enable; everything clears.
        rst   = 1'b1;
        da_in = 1'b1;
        tick(1);
        check("rst_outs", outs, 8'h00);
        check("rst_cnt", alarm_cnt, 8'd0);
        rst = 1'b0;
        tick(100);
        check("rst_warmup", outs, 8'h00);
        tick(1);
        check("rst_monitor", outs, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
